// File: rtl/reset_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : reset_sequencer                                                 |
// | Brief    : Qualifies a synchronised ready level, then releases staged      |
// |            active-low fabric resets; collapses them on lock loss or        |
// |            software request and counts filtered lock-loss events.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 8,
  parameter int LOSS_FILTER = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ready_i,
  input  logic              sw_reset_i,
  output logic [STAGES-1:0] rst_n_o,
  output logic              all_released_o,
  output logic [7:0]        loss_cnt_o,
  output logic [1:0]        state_o
);

  localparam int IDX_W = $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] C_LOSS_LAST = CNT_W'(LOSS_FILTER - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(STAGES - 1);

  state_t              r_state;
  logic [STAGES-1:0]   r_rst_n;
  logic                r_all;
  logic [7:0]          r_loss;
  logic [CNT_W-1:0]    r_hold;
  logic [CNT_W-1:0]    r_gap;
  logic [CNT_W-1:0]    r_filt;
  logic [IDX_W-1:0]    r_idx;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_ASSERT;
      r_rst_n <= '0;
      r_all   <= 1'b0;
      r_loss  <= '0;
      r_hold  <= '0;
      r_gap   <= '0;
      r_filt  <= '0;
      r_idx   <= '0;
    end else if (sw_reset_i) begin
      // Software request outranks every other transition, including a release.
      r_state <= S_ASSERT;
      r_rst_n <= '0;
      r_all   <= 1'b0;
      r_hold  <= '0;
      r_gap   <= '0;
      r_filt  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_ASSERT: begin
          if (ready_i) begin
            r_state <= S_HOLD;
            r_hold  <= '0;
          end
        end

        S_HOLD: begin
          if (!ready_i) begin
            r_state <= S_ASSERT;
            r_hold  <= '0;
          end else if (r_hold == C_HOLD_LAST) begin
            r_rst_n[0] <= 1'b1;
            r_hold     <= '0;
            r_gap      <= '0;
            r_filt     <= '0;
            r_idx      <= IDX_W'(1);
            if (STAGES == 1) begin
              r_state <= S_RUN;
              r_all   <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        default: begin
          // RELEASE and RUN share the loss filter; a loss beats a same-edge release.
          if (!ready_i && (r_filt == C_LOSS_LAST)) begin
            r_state <= S_ASSERT;
            r_rst_n <= '0;
            r_all   <= 1'b0;
            r_gap   <= '0;
            r_filt  <= '0;
            r_idx   <= '0;
            if (r_loss != 8'hFF) begin
              r_loss <= r_loss + 1'b1;
            end
          end else begin
            r_filt <= ready_i ? '0 : r_filt + 1'b1;
            if (r_state == S_RELEASE) begin
              if (r_gap == C_GAP_LAST) begin
                r_gap   <= '0;
                r_rst_n <= r_rst_n | (STAGES'(1) << r_idx);
                r_idx   <= r_idx + 1'b1;
                if (r_idx == C_IDX_LAST) begin
                  r_all   <= 1'b1;
                  r_state <= S_RUN;
                end
              end else begin
                r_gap <= r_gap + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign rst_n_o        = r_rst_n;
  assign all_released_o = r_all;
  assign loss_cnt_o     = r_loss;
  assign state_o        = r_state;

endmodule

`default_nettype wire
